// File: rtl/paddle_move_ctrl.sv
// Keypad-driven paddle mover: press/auto-repeat decode, per-player pending request, shared round-robin step engine.
// Move appears one edge after the tick grant; optional edge wrap-around via PADDLE_WRAP_EN (saturates when undefined).
module paddle_move_ctrl #(
    parameter int STEP_DIV = 4,
    parameter int REPEAT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unable,
    input  logic       key_valid,
    input  logic [3:0] keycode,
    output logic [7:0] pos1,
    output logic [7:0] pos2,
    output logic       step1,
    output logic       step2
);
    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (REPEAT > 2) ? $clog2(REPEAT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT - 1);

    logic          prev_valid;
    logic [3:0]    prev_code;
    logic [RW-1:0] rep_cnt;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    pending;
    logic [1:0]    dir;         // 1 = right (toward bit 0)
    logic          last_grant;  // 0 = P1, 1 = P2

    logic press, rpt, cmd, cmd_p1, cmd_p2, cmd_right, tick, gnt1, gnt2;

    function automatic logic [7:0] shift_pos(input logic [7:0] p, input logic right);
`ifdef PADDLE_WRAP_EN
        return right ? {p[0], p[7:1]} : {p[6:0], p[7]};
`else
        if (right)
            return p[0] ? p : {1'b0, p[7:1]};
        else
            return p[7] ? p : {p[6:0], 1'b0};
`endif
    endfunction

    always_comb begin
        press     = key_valid && (!prev_valid || (keycode != prev_code));
        rpt       = key_valid && !press && (rep_cnt == RPT_LAST);
        cmd       = (press || rpt) && !unable;
        cmd_p1    = cmd && ((keycode == 4'd1) || (keycode == 4'd2));
        cmd_p2    = cmd && ((keycode == 4'd8) || (keycode == 4'd9));
        cmd_right = (keycode == 4'd2) || (keycode == 4'd9);
        tick      = !unable && (tick_cnt == TICK_LAST);
        // On contention the player not granted last time wins.
        gnt1      = tick && pending[0] && (!pending[1] || last_grant);
        gnt2      = tick && pending[1] && (!pending[0] || !last_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_code  <= 4'd0;
            rep_cnt    <= '0;
            tick_cnt   <= '0;
            pending    <= 2'b00;
            dir        <= 2'b00;
            last_grant <= 1'b1;
            pos1       <= 8'b0001_0000;
            pos2       <= 8'b0000_1000;
            step1      <= 1'b0;
            step2      <= 1'b0;
        end else begin
            prev_valid <= key_valid;
            prev_code  <= keycode;

            if (!key_valid || press || rpt)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + 1'b1;

            if (unable || tick_cnt == TICK_LAST)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;

            step1 <= gnt1;
            step2 <= gnt2;
            if (gnt1) begin
                pos1       <= shift_pos(pos1, dir[0]);
                last_grant <= 1'b0;
            end
            if (gnt2) begin
                pos2       <= shift_pos(pos2, dir[1]);
                last_grant <= 1'b1;
            end

            // A command landing on its own grant cycle survives for a later tick.
            if (unable)
                pending <= 2'b00;
            else begin
                pending[0] <= cmd_p1 ? 1'b1 : (pending[0] && !gnt1);
                pending[1] <= cmd_p2 ? 1'b1 : (pending[1] && !gnt2);
            end
            if (cmd_p1)
                dir[0] <= cmd_right;
            if (cmd_p2)
                dir[1] <= cmd_right;
        end
    end
endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Scoreboarded bench for paddle_move_ctrl: directed scenarios then random key traffic against a reference model.
module tb_paddle_move_ctrl;
    localparam int SD = 4;
    localparam int RP = 8;
`ifdef PADDLE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       unable = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] keycode = 4'd0;
    logic [7:0] pos1, pos2;
    logic       step1, step2;

    paddle_move_ctrl #(.STEP_DIV(SD), .REPEAT(RP)) dut (
        .clk(clk), .reset(reset), .unable(unable), .key_valid(key_valid),
        .keycode(keycode), .pos1(pos1), .pos2(pos2), .step1(step1), .step2(step2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        int         who;
        logic [7:0] p1;
        logic [7:0] p2;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: positions as bit indices, events as plain flags.
    bit m_prev_v;
    int m_prev_c, m_rcnt, m_tcnt, m_last;
    bit m_pend[2];
    bit m_right[2];
    int m_idx[2];

    function automatic logic [7:0] onehot(input int i);
        logic [7:0] v;
        v = 8'd1 << i;
        return v;
    endfunction

    task automatic model(input bit rst, input bit un, input bit kv, input int kc);
        bit press, rpt;
        int who, g;
        ev_t e;
        if (rst) begin
            m_prev_v = 0; m_prev_c = 0; m_rcnt = 0; m_tcnt = 0; m_last = 1;
            m_pend[0] = 0; m_pend[1] = 0; m_right[0] = 0; m_right[1] = 0;
            m_idx[0] = 4; m_idx[1] = 3;
            return;
        end
        press = kv && (!m_prev_v || kc != m_prev_c);
        rpt = 0;
        if (!kv || press) m_rcnt = 0;
        else if (m_rcnt == RP - 1) begin rpt = 1; m_rcnt = 0; end
        else m_rcnt++;
        who = (kc == 1 || kc == 2) ? 0 : (kc == 8 || kc == 9) ? 1 : -1;
        if (un) begin
            m_pend[0] = 0; m_pend[1] = 0; m_tcnt = 0;
        end else begin
            g = -1;
            if (m_tcnt == SD - 1) begin
                if (m_pend[0] && m_pend[1]) g = 1 - m_last;
                else if (m_pend[0]) g = 0;
                else if (m_pend[1]) g = 1;
                m_tcnt = 0;
            end else m_tcnt++;
            if (g >= 0) begin
                if (m_right[g]) m_idx[g] = (m_idx[g] == 0) ? (WRAP ? 7 : 0) : m_idx[g] - 1;
                else            m_idx[g] = (m_idx[g] == 7) ? (WRAP ? 0 : 7) : m_idx[g] + 1;
                m_pend[g] = 0;
                m_last = g;
                e.cyc = cyc + 1; e.who = g; e.p1 = onehot(m_idx[0]); e.p2 = onehot(m_idx[1]);
                exp_q.push_back(e);
            end
            if ((press || rpt) && who >= 0) begin
                m_pend[who] = 1;
                m_right[who] = (kc == 2 || kc == 9);
            end
        end
        m_prev_v = kv;
        m_prev_c = kc;
    endtask

    task automatic drive(input bit rst, input bit un, input bit kv, input int kc);
        @(negedge clk);
        reset = rst; unable = un; key_valid = kv; keycode = 4'(kc);
        model(rst, un, kv, kc);
    endtask

    task automatic hold(input bit un, input bit kv, input int kc, input int n);
        for (int i = 0; i < n; i++) drive(0, un, kv, kc);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every step pulse must match the oldest expected move, in the expected cycle.
    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (step1 && step2) begin
                checks++; failures++;
                $display("FAIL both_steps: step1=%b step2=%b expected at most one", step1, step2);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missed_step: player %0d move due cycle %0d not seen", exp_q[0].who + 1, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (step1 || step2) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_step: cycle %0d step1=%b step2=%b, none expected", cyc, step1, step2);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || step1 != (e.who == 0) || step2 != (e.who == 1) ||
                        pos1 !== e.p1 || pos2 !== e.p2) begin
                        failures++;
                        $display("FAIL step_event: cycle %0d step1=%b step2=%b pos1=%h pos2=%h expected cycle %0d player %0d pos1=%h pos2=%h",
                                 cyc, step1, step2, pos1, pos2, e.cyc, e.who + 1, e.p1, e.p2);
                    end
                end
            end
        end
    end

    initial begin
        model(1, 0, 0, 0);
        do_reset();
        @(negedge clk);
        check8("reset_pos1", pos1, 8'h10);
        check8("reset_pos2", pos2, 8'h08);
        check8("reset_steps", {6'd0, step1, step2}, 8'h00);
        mon_en = 1;

        // Single P1 press
        hold(0, 1, 1, 1);
        hold(0, 0, 0, 2 * SD + 2);
        check8("single_press_pos1", pos1, 8'h20);
        check8("single_press_pos2", pos2, 8'h08);

        // Contention: P1 right then P2 left before the first tick
        do_reset();
        hold(0, 1, 2, 1);
        hold(0, 1, 8, 1);
        hold(0, 0, 0, 2 * SD + 2);
        check8("contend_pos1", pos1, 8'h08);
        check8("contend_pos2", pos2, 8'h10);

        // Auto-repeat on P2 right
        do_reset();
        hold(0, 1, 9, 3 * RP);
        hold(0, 0, 0, 2 * SD + 2);
        check8("repeat_pos2", pos2, 8'h01);

        // Left edge
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hold(0, 1, 1, 1);
            hold(0, 0, 0, 2 * SD);
        end
        check8("edge_reach", pos1, 8'h80);
        hold(0, 1, 1, 1);
        hold(0, 0, 0, 2 * SD);
        check8("edge_move", pos1, WRAP ? 8'h01 : 8'h80);

        // Freeze drops pending and new commands
        do_reset();
        hold(0, 1, 1, 1);
        hold(1, 1, 9, 2 * RP);
        hold(1, 0, 0, 1);
        hold(0, 0, 0, 3 * SD);
        check8("freeze_pos1", pos1, 8'h10);
        check8("freeze_pos2", pos2, 8'h08);

        // Ignored code then a switch to P1 right without release
        do_reset();
        hold(0, 1, 5, 2 * RP);
        hold(0, 1, 2, 3);
        hold(0, 0, 0, 2 * SD + 2);
        check8("ignored_then_change_pos1", pos1, 8'h08);

        // Random traffic
        for (int s = 0; s < 80; s++) begin
            int r, kc, len;
            int codes[10];
            codes = '{1, 2, 8, 9, 5, 0, 1, 2, 8, 9};
            r   = $urandom_range(0, 99);
            kc  = codes[$urandom_range(0, 9)];
            len = $urandom_range(1, 3 * RP);
            if (r == 99) drive(1, 0, 0, 0);
            else if (r < 10) hold(1, $urandom_range(0, 1), kc, len);
            else if (r < 25) hold(0, 0, kc, $urandom_range(1, 6));
            else hold(0, 1, kc, len);
        end
        hold(0, 0, 0, 3 * SD);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected moves outstanding, expected 0", exp_q.size());
        end
        check8("final_pos1", pos1, onehot(m_idx[0]));
        check8("final_pos2", pos2, onehot(m_idx[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
